// File: rtl/video_regs_timed.sv
// PPU register file with built-in scanline timing: dot/line counters, LYC
// coincidence, STAT mode reporting and an edge-triggered STAT interrupt.
module video_regs_timed #(
  parameter int NREGS     = 8,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int DOTS      = 456,
  parameter int LINES     = 154,
  parameter int VISIBLE   = 144,
  parameter int OAM_DOTS  = 80,
  parameter int XFER_DOTS = 172,
  parameter logic [DW-1:0] CTRL_RST = '0
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic                rdata_oe,
  input  logic                dot_tick,
  output logic [NREGS*DW-1:0] regs,
  output logic [7:0]          ly,
  output logic [1:0]          mode,
  output logic                lyc_match,
  output logic                stat_irq
);

  localparam int DOT_W = $clog2(DOTS);

  localparam int REG_CTRL = 0;
  localparam int REG_STAT = 1;
  localparam int REG_LY   = 4;
  localparam int REG_LYC  = 5;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam logic [DW-1:0] STAT_WMASK = DW'(8'h78);

  logic [DW-1:0]    reg_q [NREGS];
  logic [DW-1:0]    view  [NREGS];
  logic [DOT_W-1:0] dot_q, dot_d;
  logic [7:0]       ly_d;
  logic [1:0]       mode_d;
  logic             addr_ok, wr_en, lcd_en;
  logic             irq_line, irq_line_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    addr_ok = 1'b0;
    for (int i = 0; i < NREGS; i++)
      if (addr == AW'(i)) addr_ok = 1'b1;
  end

  assign wr_en    = cs && cpu_wr && addr_ok;
  assign rdata_oe = cs && cpu_rd && addr_ok;
  assign lcd_en   = reg_q[REG_CTRL][7];

  // NOTE: the register file is small, so it takes the async reset like any
  // other flop; every entry comes out of reset with a defined value.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREGS; i++)
        reg_q[i] <= (i == REG_CTRL) ? CTRL_RST : '0;
    end else if (wr_en) begin
      for (int i = 0; i < NREGS; i++) begin
        if (addr == AW'(i)) begin
          if (i == REG_STAT)  reg_q[i] <= wdata & STAT_WMASK;
          else if (i != REG_LY) reg_q[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    dot_d = dot_q;
    ly_d  = ly;
    if (!lcd_en) begin
      dot_d = '0;
      ly_d  = '0;
    end else if (dot_tick) begin
      if (dot_q == DOT_W'(DOTS - 1)) begin
        dot_d = '0;
        ly_d  = (ly == 8'(LINES - 1)) ? 8'd0 : ly + 8'd1;
      end else begin
        dot_d = dot_q + 1'b1;
      end
    end
  end

  // Mode is derived from the next counter values so the registered mode
  // always describes the dot/line currently held in the counters.
  always_comb begin
    mode_d = MODE_HBLANK;
    if (lcd_en) begin
      if (ly_d >= 8'(VISIBLE))                         mode_d = MODE_VBLANK;
      else if (dot_d < DOT_W'(OAM_DOTS))               mode_d = MODE_OAM;
      else if (dot_d < DOT_W'(OAM_DOTS + XFER_DOTS))   mode_d = MODE_XFER;
      else                                             mode_d = MODE_HBLANK;
    end
  end

  assign irq_line = (reg_q[REG_STAT][6] && lyc_match) ||
                    (reg_q[REG_STAT][5] && mode == MODE_OAM) ||
                    (reg_q[REG_STAT][4] && mode == MODE_VBLANK) ||
                    (reg_q[REG_STAT][3] && mode == MODE_HBLANK);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dot_q      <= '0;
      ly         <= '0;
      mode       <= MODE_HBLANK;
      lyc_match  <= 1'b0;
      irq_line_q <= 1'b0;
      stat_irq   <= 1'b0;
    end else begin
      dot_q      <= dot_d;
      ly         <= ly_d;
      mode       <= mode_d;
      lyc_match  <= (DW'(ly) == reg_q[REG_LYC]);
      irq_line_q <= irq_line;
      stat_irq   <= irq_line && !irq_line_q;
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) view[i] = reg_q[i];
    view[REG_STAT]      = '0;
    view[REG_STAT][6:3] = reg_q[REG_STAT][6:3];
    view[REG_STAT][2]   = lyc_match;
    view[REG_STAT][1:0] = mode;
    view[REG_LY]        = DW'(ly);
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREGS; i++)
      if (rdata_oe && addr == AW'(i)) rdata = view[i];
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[g*DW +: DW] = view[g];
  end

endmodule

// File: tb/tb_video_regs_timed.sv
// Directed bench for video_regs_timed: register map, STAT masking, scanline
// timing, LYC/STAT interrupts and mid-line reset, checked through a scoreboard.
module tb_video_regs_timed;
  localparam int NREGS = 8;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DOTS  = 456;
  localparam int LINES = 154;
  localparam int FRAME = DOTS * LINES;

  logic                clk = 1'b0;
  logic                nreset = 1'b1;
  logic                cs = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, dot_tick = 1'b0;
  logic [AW-1:0]       addr = '0;
  logic [DW-1:0]       wdata = '0;
  logic [DW-1:0]       rdata;
  logic                rdata_oe;
  logic [NREGS*DW-1:0] regs;
  logic [7:0]          ly;
  logic [1:0]          mode;
  logic                lyc_match, stat_irq;

  video_regs_timed #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .nreset(nreset), .cs(cs), .addr(addr), .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr), .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe),
    .dot_tick(dot_tick), .regs(regs), .ly(ly), .mode(mode),
    .lyc_match(lyc_match), .stat_irq(stat_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  compared = 0;
  int  mismatched = 0;
  int  irq_cnt = 0;
  int  irq_base = 0;
  int  pos = 0;
  bit  running = 1'b0;

  always @(negedge clk) if (stat_irq === 1'b1) irq_cnt++;

  function automatic logic [31:0] exp_mode(input int p);
    int l, d;
    l = p / DOTS;
    d = p % DOTS;
    if (l >= 144)      return 32'd1;
    else if (d < 80)   return 32'd2;
    else if (d < 252)  return 32'd3;
    else               return 32'd0;
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL scoreboard_empty: observed 0x%0h expected an entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        mismatched++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    check(obs);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (running) pos = (pos + 1) % FRAME;
  endtask

  task automatic adv(input int n);
    repeat (n) cyc();
  endtask

  task automatic adv_to(input int target);
    while (pos != target) cyc();
  endtask

  task automatic w(input int a, input logic [DW-1:0] d);
    cs = 1'b1; cpu_wr = 1'b1; addr = AW'(a); wdata = d;
    cyc();
    cs = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp_data, input logic exp_oe,
                    input string tag);
    expect_val(tag, exp_data);
    expect_val({tag, ".oe"}, 32'(exp_oe));
    cs = 1'b1; cpu_rd = 1'b1; addr = AW'(a);
    #1;
    check(32'(rdata));
    check(32'(rdata_oe));
    cs = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic st(input string tag, input logic [31:0] exp_ly);
    chk({tag, ".ly"}, 32'(ly), exp_ly);
    chk({tag, ".mode"}, 32'(mode), exp_mode(pos));
  endtask

  task automatic enable_lcd();
    dot_tick = 1'b0;
    w(0, 8'h80);
    cyc();
    pos = 0;
    dot_tick = 1'b1;
    running = 1'b1;
  endtask

  initial begin
    // Reset state, read back while reset is held.
    #2 nreset = 1'b0;
    #1;
    chk("rst.ly", 32'(ly), 0);
    chk("rst.mode", 32'(mode), 0);
    chk("rst.lyc_match", 32'(lyc_match), 0);
    chk("rst.stat_irq", 32'(stat_irq), 0);
    chk("rst.regs_lo", regs[31:0], 0);
    chk("rst.regs_hi", regs[63:32], 0);
    for (int i = 0; i < NREGS; i++) rd(i, 0, 1'b1, $sformatf("rst.rd%0d", i));
    cyc();
    nreset = 1'b1;
    cyc();

    // Plain R/W, out-of-range window, read-only LY, STAT masking.
    w(7, 8'hA5);
    rd(7, 32'hA5, 1'b1, "rw.r7");
    chk("rw.regs7", 32'(regs[7*DW +: DW]), 32'hA5);
    rd(9, 0, 1'b0, "oor.rd9");
    w(15, 8'h33);
    w(9, 8'h5A);
    rd(7, 32'hA5, 1'b1, "oor.r7_kept");
    rd(1, 32'h04, 1'b1, "oor.stat_kept");
    w(4, 8'h55);
    rd(4, 0, 1'b1, "ly.ro_off");
    w(1, 8'hFF);
    rd(1, 32'h7C, 1'b1, "stat.mask");
    w(2, 8'h12);
    rd(2, 32'h12, 1'b1, "scy.rw");

    // LYC coincidence interrupt at line 10.
    w(5, 8'd10);
    w(1, 8'h40);
    enable_lcd();
    st("l0.d0", 0);
    rd(0, 32'h80, 1'b1, "ctrl.rd");
    adv(79);  st("l0.d79", 0);
    adv(1);   st("l0.d80", 0);
    adv(171); st("l0.d251", 0);
    adv(1);   st("l0.d252", 0);
    adv(203); st("l0.d455", 0);
    adv(1);   st("l1.d0", 1);

    adv_to(10 * DOTS);
    st("l10.d0", 10);
    chk("lyc.pre", 32'(lyc_match), 0);
    irq_base = irq_cnt;
    cyc();
    chk("lyc.rise", 32'(lyc_match), 1);
    chk("lyc.irq_wait", 32'(stat_irq), 0);
    cyc();
    chk("lyc.irq_pulse", 32'(stat_irq), 1);
    rd(1, 32'h46, 1'b1, "stat.live");
    adv_to(12 * DOTS + 10);
    chk("lyc.one_pulse", 32'(irq_cnt - irq_base), 1);
    chk("lyc.fall", 32'(lyc_match), 0);
    w(4, 8'h77);
    chk("ly.ro_on", 32'(ly), 12);

    // HBLANK+VBLANK sources: STAT blocking across the vblank entry.
    w(1, 8'h18);
    adv_to(143 * DOTS + 251);
    st("l143.d251", 143);
    irq_base = irq_cnt;
    adv(1); st("l143.d252", 143);
    adv_to(144 * DOTS);
    st("l144.d0", 144);
    adv_to(153 * DOTS + 455);
    st("l153.d455", 153);
    chk("vbl.blocked", 32'(irq_cnt - irq_base), 1);
    cyc();
    st("wrap.d0", 0);
    adv_to(253);
    chk("wrap.hbl_pulse", 32'(stat_irq), 1);
    cyc();
    chk("wrap.count", 32'(irq_cnt - irq_base), 2);

    // Asynchronous reset mid-line while an interrupt pulse is high.
    adv_to(DOTS + 253);
    chk("mid.pulse", 32'(stat_irq), 1);
    chk("mid.ly", 32'(ly), 1);
    nreset = 1'b0;
    running = 1'b0;
    #1;
    chk("arst.ly", 32'(ly), 0);
    chk("arst.mode", 32'(mode), 0);
    chk("arst.stat_irq", 32'(stat_irq), 0);
    chk("arst.lyc_match", 32'(lyc_match), 0);
    rd(0, 0, 1'b1, "arst.ctrl");
    rd(5, 0, 1'b1, "arst.lyc");
    rd(7, 0, 1'b1, "arst.r7");
    cyc();
    nreset = 1'b1;
    cyc();
    rd(1, 32'h04, 1'b1, "arst.stat");

    // Restart from dot 0 of line 0, then LCD off forces counters to zero.
    enable_lcd();
    st("re.d0", 0);
    adv(80);
    st("re.d80", 0);
    w(0, 8'h00);
    running = 1'b0;
    cyc();
    chk("off.ly", 32'(ly), 0);
    chk("off.mode", 32'(mode), 0);
    adv(5);
    chk("off.mode_hold", 32'(mode), 0);
    rd(1, 32'h04, 1'b1, "off.stat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
